assert_monitor_mc: RTL and testbench

Multi-channel, parametrised successor to our single-channel overflow/assert test block for GEM assertion support. Registers NCH data lanes and detects the "all-ones data while cycle counter exceeds THRESH" violation per lane. Keeps sticky per-lane flags and a saturating violation count, and logs each violating cycle into a small event FIFO drained by a valid/ready port. In FORMAL builds it also emits immediate assertions, which synthesise to $assert/$check cells, so the same design exercises both the RTL path and the assertion path.

---
 rtl/assert_monitor_mc.sv | 134 +++++++++++++
 tb/tb_assert_monitor_mc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/assert_monitor_mc.sv
// Multi-lane overflow/assert monitor: flags all-ones lane data seen while the cycle
// counter is past THRESH, counts violating cycles and queues one event per such cycle.
module assert_monitor_mc #(
  parameter int NCH    = 4,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4,
  parameter int THRESH = 10,
  parameter int DEPTH  = 4,
  parameter int VCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*DATA_W-1:0] data_in,
  input  logic [NCH-1:0]        valid_in,
  input  logic [NCH-1:0]        clr,
  output logic [NCH*DATA_W-1:0] data_out,
  output logic [NCH-1:0]        overflow_flag,
  output logic [CNT_W-1:0]      counter,
  output logic [VCNT_W-1:0]     viol_count,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [NCH-1:0]        ev_mask,
  output logic [CNT_W-1:0]      ev_cnt,
  output logic [VCNT_W-1:0]     ev_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [NCH*DATA_W-1:0] data_q;
  logic [NCH-1:0]        flag_q, flag_d;
  logic [CNT_W-1:0]      counter_q;
  logic [VCNT_W-1:0]     viol_q, viol_d;
  logic [VCNT_W-1:0]     drop_q, drop_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;

  logic [NCH-1:0]        mem_mask [DEPTH];
  logic [CNT_W-1:0]      mem_cnt  [DEPTH];

  logic [NCH-1:0]        lane_ones;
  logic [NCH-1:0]        v_raw;
  logic [NCH-1:0]        v;
  logic                  cnt_over;
  logic                  any_v;
  logic                  fifo_full;
  logic                  pop;
  logic                  push_ok;
  logic                  drop_ev;

  assign cnt_over = counter_q > CNT_W'(THRESH);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    assign lane_ones[gi] = &data_in[gi*DATA_W +: DATA_W];
    assign v_raw[gi]     = valid_in[gi] & lane_ones[gi] & cnt_over;
  end

  assign v     = v_raw & {NCH{~rst}};
  assign any_v = |v;

  assign ev_valid  = (occ_q != '0);
  assign fifo_full = (occ_q == OW'(DEPTH));
  assign pop       = ev_valid & ev_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = any_v & (~fifo_full | pop);
  assign drop_ev   = any_v & fifo_full & ~pop;

  always_comb begin
    flag_d   = (flag_q & ~clr) | v;
    viol_d   = viol_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + OW'(push_ok) - OW'(pop);
    if (any_v && viol_q != '1) begin
      viol_d = viol_q + 1'b1;
    end
    if (drop_ev && drop_q != '1) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      flag_q    <= '0;
      counter_q <= '0;
      viol_q    <= '0;
      drop_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      data_q    <= data_in;
      flag_q    <= flag_d;
      counter_q <= counter_q + 1'b1;
      viol_q    <= viol_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  // Payload storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_mask[wr_ptr_q] <= v;
      mem_cnt[wr_ptr_q]  <= counter_q;
    end
  end

  assign data_out      = data_q;
  assign overflow_flag = flag_q;
  assign counter       = counter_q;
  assign viol_count    = viol_q;
  assign ev_drop       = drop_q;
  assign ev_mask       = ev_valid ? mem_mask[rd_ptr_q] : '0;
  assign ev_cnt        = ev_valid ? mem_cnt[rd_ptr_q]  : '0;

`ifdef FORMAL
  for (genvar gi = 0; gi < NCH; gi++) begin : g_fassert
    always @(posedge clk) begin
      assert (rst || !v_raw[gi]);
    end
  end

  always @(posedge clk) begin
    assert (occ_q <= OW'(DEPTH));
  end
`endif

endmodule

// File: tb/tb_assert_monitor_mc.sv
// Directed bench for assert_monitor_mc: vector table plus hand-written corner sequences.
module tb_assert_monitor_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  valid_in;
  logic [3:0]  clr;
  logic        ev_ready;
  logic [15:0] data_out, data_out2;
  logic [3:0]  overflow_flag, overflow_flag2;
  logic [3:0]  counter, counter2;
  logic [7:0]  viol_count;
  logic [1:0]  viol_count2;
  logic        ev_valid, ev_valid2;
  logic [3:0]  ev_mask, ev_mask2;
  logic [3:0]  ev_cnt, ev_cnt2;
  logic [7:0]  ev_drop;
  logic [1:0]  ev_drop2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assert_monitor_mc u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .clr(clr),
    .data_out(data_out), .overflow_flag(overflow_flag), .counter(counter),
    .viol_count(viol_count), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_mask(ev_mask), .ev_cnt(ev_cnt), .ev_drop(ev_drop)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  assert_monitor_mc #(.VCNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .clr(clr),
    .data_out(data_out2), .overflow_flag(overflow_flag2), .counter(counter2),
    .viol_count(viol_count2), .ev_valid(ev_valid2), .ev_ready(ev_ready),
    .ev_mask(ev_mask2), .ev_cnt(ev_cnt2), .ev_drop(ev_drop2)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] data;
    logic [3:0]  clr;
    logic        ready;
    logic [3:0]  e_counter;
    logic [3:0]  e_flag;
    logic [7:0]  e_vcnt;
    logic        e_valid;
    logic [3:0]  e_mask;
    logic [3:0]  e_evcnt;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] vl, input logic [15:0] d,
                              input logic [3:0] cl, input logic rdy, input logic [3:0] ec,
                              input logic [3:0] ef, input logic [7:0] evc, input logic ev,
                              input logic [3:0] em, input logic [3:0] ecn, input logic [7:0] ed);
    vec_t t;
    t.rst = r; t.valid = vl; t.data = d; t.clr = cl; t.ready = rdy;
    t.e_counter = ec; t.e_flag = ef; t.e_vcnt = evc; t.e_valid = ev;
    t.e_mask = em; t.e_evcnt = ecn; t.e_drop = ed;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = '0; data_in = '0; clr = '0; ev_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_v, exp_drop, occ;
    rst = 1'b1; valid_in = '0; data_in = '0; clr = '0; ev_ready = 1'b0;

    // Reset, then all lanes all-ones: first violation at counter 11
    add(1, 4'h0, 16'h0000, 4'h0, 0, 4'd0, 4'h0, 8'd0, 0, 4'h0, 4'd0, 8'd0);
    for (int c = 0; c <= 10; c++)
      add(0, 4'hF, 16'hFFFF, 4'h0, 0, 4'(c + 1), 4'h0, 8'd0, 0, 4'h0, 4'd0, 8'd0);
    add(0, 4'hF, 16'hFFFF, 4'h0, 0, 4'd12, 4'hF, 8'd1, 1, 4'hF, 4'd11, 8'd0);
    // Lane 2 only, FIFO fills at 11..14, 15 is dropped, then drain
    add(1, 4'h0, 16'h0000, 4'h0, 0, 4'd0, 4'h0, 8'd0, 0, 4'h0, 4'd0, 8'd0);
    for (int c = 0; c <= 10; c++)
      add(0, 4'b0100, 16'h0F00, 4'h0, 0, 4'(c + 1), 4'h0, 8'd0, 0, 4'h0, 4'd0, 8'd0);
    for (int c = 11; c <= 15; c++)
      add(0, 4'b0100, 16'h0F00, 4'h0, 0, 4'(c + 1), 4'b0100, 8'(c - 10), 1, 4'b0100,
          4'd11, (c == 15) ? 8'd1 : 8'd0);
    add(0, 4'h0, 16'h0000, 4'h0, 1, 4'd1, 4'b0100, 8'd5, 1, 4'b0100, 4'd12, 8'd1);
    add(0, 4'h0, 16'h0000, 4'h0, 1, 4'd2, 4'b0100, 8'd5, 1, 4'b0100, 4'd13, 8'd1);
    add(0, 4'h0, 16'h0000, 4'h0, 1, 4'd3, 4'b0100, 8'd5, 1, 4'b0100, 4'd14, 8'd1);
    add(0, 4'h0, 16'h0000, 4'h0, 1, 4'd4, 4'b0100, 8'd5, 0, 4'h0, 4'd0, 8'd1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; valid_in = vecs[i].valid; data_in = vecs[i].data;
      clr = vecs[i].clr; ev_ready = vecs[i].ready;
      tick();
      chk($sformatf("v%0d counter", i), 32'(counter), 32'(vecs[i].e_counter));
      chk($sformatf("v%0d data_out", i), 32'(data_out), vecs[i].rst ? 32'd0 : 32'(vecs[i].data));
      chk($sformatf("v%0d flag", i), 32'(overflow_flag), 32'(vecs[i].e_flag));
      chk($sformatf("v%0d viol_count", i), 32'(viol_count), 32'(vecs[i].e_vcnt));
      chk($sformatf("v%0d ev_valid", i), 32'(ev_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d ev_mask", i), 32'(ev_mask), 32'(vecs[i].e_mask));
      chk($sformatf("v%0d ev_cnt", i), 32'(ev_cnt), 32'(vecs[i].e_evcnt));
      chk($sformatf("v%0d ev_drop", i), 32'(ev_drop), 32'(vecs[i].e_drop));
      $display("vec %0d: cnt=%0d flag=%b vcnt=%0d evv=%b mask=%b evcnt=%0d drop=%0d",
               i, counter, overflow_flag, viol_count, ev_valid, ev_mask, ev_cnt, ev_drop);
    end

    // Set and clear on the same lane in the same cycle: set wins
    do_reset();
    repeat (11) tick();
    valid_in = 4'b0011; data_in = 16'hFFFF; clr = 4'b0010;
    tick();
    chk("setclr flag", 32'(overflow_flag), 32'h3);
    chk("setclr vcnt", 32'(viol_count), 32'd1);
    valid_in = 4'b0000;
    tick();
    chk("clr_only flag", 32'(overflow_flag), 32'h1);
    clr = 4'b0000;
    $display("seq setclr: flag=%b vcnt=%0d", overflow_flag, viol_count);

    // Full FIFO with push and pop together: no drop, head advances
    do_reset();
    repeat (11) tick();
    valid_in = 4'b0001; data_in = 16'h000F;
    repeat (4) tick();
    chk("full head", 32'(ev_cnt), 32'd11);
    chk("full drop", 32'(ev_drop), 32'd0);
    ev_ready = 1'b1;
    tick();
    chk("pushpop drop", 32'(ev_drop), 32'd0);
    chk("pushpop head", 32'(ev_cnt), 32'd12);
    chk("pushpop vcnt", 32'(viol_count), 32'd5);
    valid_in = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("drain%0d head", k), 32'(ev_cnt), 32'(13 + k));
      chk($sformatf("drain%0d mask", k), 32'(ev_mask), 32'h1);
    end
    tick();
    chk("drain empty", 32'(ev_valid), 32'd0);
    $display("seq pushpop: evv=%b drop=%0d", ev_valid, ev_drop);

    // Unqualified all-ones data, then reset in the middle of a burst
    do_reset();
    repeat (12) tick();
    valid_in = 4'h0; data_in = 16'hFFFF;
    tick();
    chk("novalid dout", 32'(data_out), 32'hFFFF);
    chk("novalid flag", 32'(overflow_flag), 32'h0);
    chk("novalid vcnt", 32'(viol_count), 32'd0);
    chk("novalid evv", 32'(ev_valid), 32'd0);
    valid_in = 4'hF;
    tick();
    chk("burst flag", 32'(overflow_flag), 32'hF);
    chk("burst evv", 32'(ev_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst counter", 32'(counter), 32'd0);
    chk("midrst dout", 32'(data_out), 32'd0);
    chk("midrst flag", 32'(overflow_flag), 32'h0);
    chk("midrst vcnt", 32'(viol_count), 32'd0);
    chk("midrst evv", 32'(ev_valid), 32'd0);
    chk("midrst mask", 32'(ev_mask), 32'd0);
    chk("midrst evcnt", 32'(ev_cnt), 32'd0);
    chk("midrst drop", 32'(ev_drop), 32'd0);
    $display("seq midrst: cnt=%0d evv=%b", counter, ev_valid);

    // Two counter laps of continuous violations; only counter > 10 counts
    do_reset();
    valid_in = 4'hF; data_in = 16'hFFFF;
    exp_v = 0; exp_drop = 0; occ = 0;
    for (int i = 0; i < 32; i++) begin
      if ((i % 16) > 10) begin
        exp_v++;
        if (occ < 4) occ++;
        else exp_drop++;
      end
      tick();
      chk($sformatf("wrap%0d counter", i), 32'(counter), 32'((i + 1) % 16));
      chk($sformatf("wrap%0d vcnt", i), 32'(viol_count), 32'(exp_v));
      chk($sformatf("wrap%0d vcnt2", i), 32'(viol_count2), 32'((exp_v > 3) ? 3 : exp_v));
      $display("wrap %0d: cnt=%0d vcnt=%0d vcnt2=%0d", i, counter, viol_count, viol_count2);
    end
    chk("wrap drop", 32'(ev_drop), 32'(exp_drop));
    chk("wrap drop2", 32'(ev_drop2), 32'((exp_drop > 3) ? 3 : exp_drop));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
